// File: rtl/snd_clk_pkg.sv
// Shared types and constants for the audio bit/frame clock generator.
// Config fields are sized to fixed maxima so one struct serves every DIV_W/SLOT_W choice.
package snd_clk_pkg;

    localparam int MAX_DIV_W  = 16;
    localparam int MAX_SLOT_W = 16;

    localparam logic MODE_PCM = 1'b0;
    localparam logic MODE_DSD = 1'b1;

    localparam int unsigned DEFAULT_HALF_DIV  = 0;
    localparam int unsigned DEFAULT_SLOT_BITS = 31;
    localparam bit          DEFAULT_MODE      = 1'b0;

    typedef struct packed {
        logic [MAX_DIV_W-1:0]  half_div;
        logic [MAX_SLOT_W-1:0] slot_bits;
        logic                  mode;
    } snd_cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    function automatic snd_cfg_t make_cfg(input int unsigned half_div,
                                          input int unsigned slot_bits,
                                          input logic        mode);
        snd_cfg_t c;
        c.half_div  = MAX_DIV_W'(half_div);
        c.slot_bits = MAX_SLOT_W'(slot_bits);
        c.mode      = mode;
        return c;
    endfunction

endpackage

// File: rtl/snd_clkgen_if.sv
// Control/status bundle of the clock generator: enable, config request and the generated clocks/strobes.
interface snd_clkgen_if #(
    parameter int DIV_W  = 8,
    parameter int SLOT_W = 6
);
    logic              en;
    logic              cfg_load;
    logic [DIV_W-1:0]  cfg_half_div;
    logic [SLOT_W-1:0] cfg_slot_bits;
    logic              cfg_mode;
    logic              cfg_busy;
    logic              bclk;
    logic              lrclk;
    logic              bclk_rise;
    logic              bclk_fall;
    logic              frame_start;

    modport master (
        output en, cfg_load, cfg_half_div, cfg_slot_bits, cfg_mode,
        input  cfg_busy, bclk, lrclk, bclk_rise, bclk_fall, frame_start
    );

    modport slave (
        input  en, cfg_load, cfg_half_div, cfg_slot_bits, cfg_mode,
        output cfg_busy, bclk, lrclk, bclk_rise, bclk_fall, frame_start
    );

endinterface

// File: rtl/snd_clkgen_cfg.sv
// Double-buffered configuration: a pending slot loaded on request and an active slot
// updated only at frame boundaries (or at once while the generator is stopped).
module snd_clkgen_cfg
    import snd_clk_pkg::*;
#(
    parameter int unsigned DEF_HALF_DIV  = DEFAULT_HALF_DIV,
    parameter int unsigned DEF_SLOT_BITS = DEFAULT_SLOT_BITS,
    parameter bit          DEF_MODE      = DEFAULT_MODE
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     en_i,
    input  logic     load_i,
    input  logic     apply_i,
    input  snd_cfg_t req_i,
    output logic     busy_o,
    output snd_cfg_t active_o
);

    localparam snd_cfg_t RESET_CFG = make_cfg(DEF_HALF_DIV, DEF_SLOT_BITS, DEF_MODE);

    snd_cfg_t pend_q, pend_d;
    snd_cfg_t active_q, active_d;
    logic     busy_q, busy_d;

    // A load seen while busy is dropped so the first requested config is the one applied.
    always_comb begin
        pend_d   = pend_q;
        active_d = active_q;
        busy_d   = busy_q;
        if (!en_i) begin
            if (busy_q) begin
                active_d = pend_q;
                busy_d   = 1'b0;
            end else if (load_i) begin
                active_d = req_i;
            end
        end else if (apply_i && busy_q) begin
            active_d = pend_q;
            busy_d   = 1'b0;
        end else if (load_i && !busy_q) begin
            pend_d = req_i;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q   <= RESET_CFG;
            active_q <= RESET_CFG;
            busy_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            active_q <= active_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign active_o = active_q;

endmodule

// File: rtl/snd_clkgen.sv
// Audio BCLK/LRCLK generator running on MCLK, with registered MCLK-domain edge and frame strobes.
// Config swaps land on frame boundaries, where every counter is already back at zero.
module snd_clkgen
    import snd_clk_pkg::*;
#(
    parameter int          DIV_W         = 8,
    parameter int          SLOT_W        = 6,
    parameter int unsigned DEF_HALF_DIV  = DEFAULT_HALF_DIV,
    parameter int unsigned DEF_SLOT_BITS = DEFAULT_SLOT_BITS,
    parameter bit          DEF_MODE      = DEFAULT_MODE
) (
    input  logic         mclk_i,
    input  logic         mrst_n_i,
    snd_clkgen_if.slave  bus
);

    run_state_e        state_q, state_d;
    logic [DIV_W-1:0]  hcnt_q, hcnt_d;
    logic [SLOT_W-1:0] bcnt_q, bcnt_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              fs_q, fs_d;
    logic              hwrap;
    logic              slot_end;
    logic              busy;
    snd_cfg_t          req;
    snd_cfg_t          active;

    assign req = '{half_div:  MAX_DIV_W'(bus.cfg_half_div),
                   slot_bits: MAX_SLOT_W'(bus.cfg_slot_bits),
                   mode:      bus.cfg_mode};

    snd_clkgen_cfg #(
        .DEF_HALF_DIV (DEF_HALF_DIV),
        .DEF_SLOT_BITS(DEF_SLOT_BITS),
        .DEF_MODE     (DEF_MODE)
    ) u_cfg (
        .clk_i   (mclk_i),
        .rst_n_i (mrst_n_i),
        .en_i    (bus.en),
        .load_i  (bus.cfg_load),
        .apply_i (fs_d),
        .req_i   (req),
        .busy_o  (busy),
        .active_o(active)
    );

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        fs_d     = 1'b0;
        hwrap    = 1'b0;
        slot_end = 1'b0;
        if (!bus.en) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
            bcnt_d  = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
        end else begin
            state_d  = ST_RUN;
            hwrap    = (MAX_DIV_W'(hcnt_q) == active.half_div);
            hcnt_d   = hwrap ? '0 : hcnt_q + DIV_W'(1);
            bclk_d   = bclk_q ^ hwrap;
            rise_d   = hwrap & ~bclk_q;
            fall_d   = hwrap & bclk_q;
            slot_end = fall_d & (MAX_SLOT_W'(bcnt_q) == active.slot_bits);
            if (fall_d) begin
                bcnt_d = slot_end ? '0 : bcnt_q + SLOT_W'(1);
            end
            if (active.mode == MODE_DSD) begin
                lrclk_d = 1'b0;
                fs_d    = slot_end;
            end else begin
                lrclk_d = lrclk_q ^ slot_end;
                fs_d    = slot_end & lrclk_q;
            end
            // The first enabled edge of a run always opens a frame on the left channel.
            if (state_q == ST_IDLE) begin
                lrclk_d = 1'b0;
                fs_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk_i or negedge mrst_n_i) begin
        if (!mrst_n_i) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.cfg_busy    = busy;
    assign bus.bclk        = bclk_q;
    assign bus.lrclk       = lrclk_q;
    assign bus.bclk_rise   = rise_q;
    assign bus.bclk_fall   = fall_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_snd_clkgen.sv
// Bench for snd_clkgen: directed scenarios plus random traffic, checked every MCLK cycle
// against an arithmetic model that derives clock phases from the edge count since frame origin.
module tb_snd_clkgen;

    logic mclk   = 1'b0;
    logic mrst_n = 1'b0;

    snd_clkgen_if #(.DIV_W(8), .SLOT_W(6)) bus ();

    snd_clkgen #(
        .DIV_W        (8),
        .SLOT_W       (6),
        .DEF_HALF_DIV (0),
        .DEF_SLOT_BITS(31),
        .DEF_MODE     (1'b0)
    ) dut (
        .mclk_i  (mclk),
        .mrst_n_i(mrst_n),
        .bus     (bus)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        int hd;
        int sb;
        bit dsd;
    } cfgModel_t;

    cfgModel_t mAct, mPend;
    bit        mBusy, mRunning;
    int        mK;
    bit        expBclk, expLr, expRise, expFall, expFs;
    int        numVectors     = 0;
    int        numMiscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        mAct     = '{hd: 0, sb: 31, dsd: 1'b0};
        mPend    = mAct;
        mBusy    = 1'b0;
        mRunning = 1'b0;
        mK       = 0;
        expBclk  = 1'b0;
        expLr    = 1'b0;
        expRise  = 1'b0;
        expFall  = 1'b0;
        expFs    = 1'b0;
    endtask

    // mK counts enabled edges since the last point where all counters were zero.
    task automatic modelStep(input bit en, input bit ld, input cfgModel_t req);
        bit startEdge, slotEnd, fs;
        int h, s, tog, f;
        if (!en) begin
            if (mBusy) begin
                mAct  = mPend;
                mBusy = 1'b0;
            end else if (ld) begin
                mAct = req;
            end
            mRunning = 1'b0;
            mK       = 0;
            expBclk  = 1'b0;
            expLr    = 1'b0;
            expRise  = 1'b0;
            expFall  = 1'b0;
            expFs    = 1'b0;
        end else begin
            startEdge = !mRunning;
            mRunning  = 1'b1;
            mK        = startEdge ? 1 : mK + 1;
            h         = mAct.hd + 1;
            s         = mAct.sb + 1;
            tog       = mK / h;
            f         = mK / (2 * h);
            expBclk   = (tog % 2) == 1;
            expRise   = (mK % h == 0) && (tog % 2 == 1);
            expFall   = (mK % h == 0) && (tog % 2 == 0);
            slotEnd   = expFall && (f % s == 0);
            if (mAct.dsd) begin
                expLr = 1'b0;
                fs    = slotEnd;
            end else begin
                expLr = ((f / s) % 2) == 1;
                fs    = slotEnd && ((f / s) % 2 == 0);
            end
            if (startEdge) begin
                fs    = 1'b1;
                expLr = 1'b0;
            end
            expFs = fs;
            if (fs && mBusy) begin
                mAct  = mPend;
                mBusy = 1'b0;
                mK    = 0;
            end else if (ld && !mBusy) begin
                mPend = req;
                mBusy = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("bclk",        bus.bclk,        expBclk);
        checkOutput("lrclk",       bus.lrclk,       expLr);
        checkOutput("bclk_rise",   bus.bclk_rise,   expRise);
        checkOutput("bclk_fall",   bus.bclk_fall,   expFall);
        checkOutput("frame_start", bus.frame_start, expFs);
        checkOutput("cfg_busy",    bus.cfg_busy,    mBusy);
    endtask

    task automatic applyStimulus(input bit en, input bit ld, input int hd, input int sb,
                                 input bit dsd, input int cycles);
        cfgModel_t req;
        req = '{hd: hd, sb: sb, dsd: dsd};
        for (int c = 0; c < cycles; c++) begin
            bus.en            = en;
            bus.cfg_load      = ld && (c == 0);
            bus.cfg_half_div  = 8'(hd);
            bus.cfg_slot_bits = 6'(sb);
            bus.cfg_mode      = dsd;
            @(posedge mclk);
            modelStep(en, ld && (c == 0), req);
            #1 checkAll();
        end
    endtask

    // Reset lands between MCLK edges so the outputs must clear without any clock.
    task automatic asyncReset(input string tag);
        #2 mrst_n = 1'b0;
        #1;
        checkOutput({tag, "_bclk"},  bus.bclk,        0);
        checkOutput({tag, "_lrclk"}, bus.lrclk,       0);
        checkOutput({tag, "_rise"},  bus.bclk_rise,   0);
        checkOutput({tag, "_fall"},  bus.bclk_fall,   0);
        checkOutput({tag, "_fs"},    bus.frame_start, 0);
        checkOutput({tag, "_busy"},  bus.cfg_busy,    0);
        modelReset();
        #2 mrst_n = 1'b1;
    endtask

    initial begin
        bit en, ld, dsd;
        int hd, sb;
        bus.en            = 1'b0;
        bus.cfg_load      = 1'b0;
        bus.cfg_half_div  = '0;
        bus.cfg_slot_bits = '0;
        bus.cfg_mode      = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_bclk", bus.bclk,        0);
        checkOutput("reset_fs",   bus.frame_start, 0);
        checkOutput("reset_busy", bus.cfg_busy,    0);
        mrst_n = 1'b1;

        $display("[TB] defaults: HALF_DIV=0 SLOT_BITS=31 PCM");
        applyStimulus(1'b1, 1'b0, 0, 31, 1'b0, 300);

        $display("[TB] load HALF_DIV=1 SLOT_BITS=3 while stopped");
        applyStimulus(1'b0, 1'b1, 1, 3, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 1, 3, 1'b0, 97);

        $display("[TB] mid-slot reconfig, second load ignored");
        applyStimulus(1'b1, 1'b1, 3, 3, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 2, 1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 200);

        $display("[TB] DSD SLOT_BITS=7 HALF_DIV=0");
        applyStimulus(1'b0, 1'b1, 0, 7, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 0, 7, 1'b1, 100);

        $display("[TB] PCM->DSD switch at a frame boundary, SLOT_BITS=0 edge cases");
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 1, 0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 40);

        $display("[TB] asynchronous reset mid-frame with a pending config");
        applyStimulus(1'b1, 1'b1, 2, 5, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 3);
        asyncReset("arst");
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 150);

        $display("[TB] random traffic");
        for (int i = 0; i < 2500; i++) begin
            en  = ($urandom_range(0, 49) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            hd  = int'($urandom_range(0, 3));
            sb  = int'($urandom_range(0, 7));
            dsd = 1'($urandom_range(0, 1));
            applyStimulus(en, ld, hd, sb, dsd, 1);
            if (i == 1200) asyncReset("arst2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/snd_clkgen.md
Name: snd_clkgen

Overview:
- Parametrised audio bit-clock and frame-clock generator for the DAC datapath, clocked by the master clock MCLK.
- Produces BCLK with a runtime-programmable divide ratio, plus LRCLK (PCM) or a word strobe (DSD).
- Also produces single-cycle MCLK-domain edge strobes, so shifters stay synchronous to MCLK.
- Configuration changes are double-buffered and take effect only at frame boundaries, so BCLK/LRCLK never glitch.

Parameters:
DIV_W, 8, width of HALF_DIV; BCLK half-period is HALF_DIV+1 MCLK cycles
SLOT_W, 6, width of SLOT_BITS; a slot (LR half, or DSD word) is SLOT_BITS+1 BCLK periods
DEF_HALF_DIV, 0, active HALF_DIV after reset (BCLK = MCLK/2)
DEF_SLOT_BITS, 31, active SLOT_BITS after reset
DEF_MODE, 0, active mode after reset (0 = PCM, 1 = DSD)

Ports:
MCLK  in  1  master clock, sole clock
MRST_N  in  1  asynchronous active-low reset
EN  in  1  run enable, sampled on MCLK
CFG_LOAD  in  1  one-cycle request to load the CFG_* inputs
CFG_HALF_DIV  in  DIV_W  requested HALF_DIV
CFG_SLOT_BITS  in  SLOT_W  requested SLOT_BITS
CFG_MODE  in  1  requested mode
CFG_BUSY  out  1  pending config not yet applied
BCLK  out  1  bit clock, registered
LRCLK  out  1  frame clock: PCM 0 = left, 1 = right; DSD held 0
BCLK_RISE  out  1  high during the first MCLK cycle in which BCLK=1
BCLK_FALL  out  1  high during the first MCLK cycle in which BCLK=0 after a high phase
FRAME_START  out  1  one-cycle start-of-frame/word strobe

Behaviour:
- Reset (MRST_N=0, asynchronous): all counters 0; BCLK=0, LRCLK=0, all strobes 0, CFG_BUSY=0; active config = DEF_*.
- EN=0: on the next MCLK edge, clear hcnt and bcnt and force BCLK=0, LRCLK=0 and all strobes 0. A pending config applies immediately and clears CFG_BUSY on that edge.
- In the first cycle of a run (EN=1 after EN=0 or after reset), FRAME_START=1 and LRCLK=0.
- Half counter hcnt (DIV_W bits):
  - Each enabled edge: if hcnt==HALF_DIV, then hcnt<=0 and BCLK toggles; else hcnt increments.
  - The first BCLK rise follows HALF_DIV+1 enabled edges.
  - BCLK period = 2*(HALF_DIV+1) MCLK cycles, 50% duty.
- Bit counter bcnt (SLOT_W bits) advances on each BCLK 1->0 toggle. At bcnt==SLOT_BITS it wraps to 0 and a slot boundary occurs in that same cycle.
- PCM mode:
  - LRCLK toggles at each slot boundary, in the same cycle as BCLK_FALL.
  - FRAME_START pulses when LRCLK goes 1->0.
  - LRCLK period = 2*(SLOT_BITS+1) BCLK periods.
- DSD mode: LRCLK stays 0 and FRAME_START pulses at every slot boundary (word strobe for the DSD shifter).
- Strobes: registered; they assert in the same cycle as the BCLK/LRCLK register changes.
- Config handshake:
  - CFG_LOAD with CFG_BUSY=0 captures CFG_* into the pending register and sets CFG_BUSY=1 on the next edge.
  - CFG_LOAD with CFG_BUSY=1 is ignored; the pending value is not overwritten.
  - The pending config becomes active at the next FRAME_START cycle. hcnt, bcnt and LRCLK restart from 0 under the new config, and CFG_BUSY clears in that cycle.
  - A CFG_LOAD in the same cycle as a FRAME_START is captured but applies at the following FRAME_START, not the current one.
- Mode switch PCM->DSD: LRCLK forced 0 at the switch boundary.
- Width rules:
  - Counters compare with ==, so no overflow is possible.
  - HALF_DIV=0 and SLOT_BITS=0 are legal. With SLOT_BITS=0, FRAME_START pulses every BCLK (DSD) or every second BCLK fall (PCM).
- MRST_N asserted mid-frame: immediate clear; a pending config is discarded.

Decomposition:
- Package snd_clk_pkg holds:
  - mode constants MODE_PCM=0 and MODE_DSD=1;
  - default constants for DEF_HALF_DIV and DEF_SLOT_BITS;
  - a config struct {half_div, slot_bits, mode}.
- One sub-module, snd_clkgen_cfg, holds the pending/active config registers, CFG_BUSY and the apply logic.
- The counters and output registers stay in snd_clkgen.

Test Plan:
- Reset then EN=1 with defaults -> BCLK toggles every MCLK cycle; FRAME_START at run start, then every 64 BCLK periods (128 MCLK); LRCLK period 128 MCLK.
- CFG_LOAD HALF_DIV=1, SLOT_BITS=3, PCM with EN=0 -> CFG_BUSY=0 next cycle. EN=1 -> BCLK period 4 MCLK, LRCLK period 32 MCLK; exactly one BCLK_RISE and one BCLK_FALL per BCLK period.
- Running at HALF_DIV=1/SLOT_BITS=3; CFG_LOAD HALF_DIV=3 mid-slot -> CFG_BUSY=1 until the next FRAME_START. Old 4-cycle BCLK continues to that boundary with no runt pulse, then 8-cycle BCLK.
- Second CFG_LOAD while CFG_BUSY=1 -> ignored; the first requested config is the one applied.
- DSD, SLOT_BITS=7, HALF_DIV=0 -> LRCLK constant 0; FRAME_START every 16 MCLK, coincident with BCLK_FALL.
- Pull MRST_N low mid-frame asynchronously -> all outputs 0 immediately with no MCLK edge; after release, DEF_* config is active.
